regfile_wb: RTL and testbench
=============================

Name: regfile_wb

Overview:
- Writer-side endpoint of the destination-register select path in the single-cycle CPU.
- Receives the 5-bit write address chosen by the RegDst select mux, together with write-back data and write enable.
- Stores 2**AW registers of DW bits each, with two combinational read ports for the decode stage.
- Adds a debug read port, an optional same-cycle write-to-read bypass, and a committed-write counter for verification.

Parameters:
- DW, 32, data width of each register.
- AW, 5, address width; the register count is 2**AW. AW matches the N=5 width of the destination select.
- BYPASS, 1, when 1, a read of the address being written in the current cycle returns the incoming write data; when 0, it returns the stored value.
- CW, 16, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- we  input  1  write enable (RegWrite).
- wa  input  AW  write address, taken from the destination select mux output.
- wd  input  DW  write-back data.
- ra1  input  AW  read address, port 1 (rs).
- ra2  input  AW  read address, port 2 (rt).
- rd1  output  DW  read data, port 1.
- rd2  output  DW  read data, port 2.
- dbg_addr  input  AW  debug read address.
- dbg_data  output  DW  debug read data. Never bypassed.
- wr_count  output  CW  count of committed writes.
- last_wa  output  AW  address of the most recent committed write.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. No asynchronous reset path exists.
- Reset: on a rising edge with rst=1, the following are cleared to 0:
  - all registers;
  - wr_count;
  - last_wa.
  - Outputs then read 0 for every address from the following cycle onward.
- Reset vs. write: rst has priority over we on the same edge. A write presented together with rst is discarded and does not increment wr_count.
- Reset mid-operation: asserting rst between writes clears all state at that edge. Writes resume on the first edge with rst=0.
- Write: on a rising edge with rst=0, we=1 and wa!=0:
  - reg[wa] <= wd;
  - wr_count <= wr_count+1;
  - last_wa <= wa.
  - Latency is 1 cycle: the value is visible on a non-bypassed read from the cycle after the edge.
- Register 0: hardwired to 0.
  - A write with wa=0 is dropped.
  - wr_count and last_wa are unchanged by it.
  - Reads of address 0 always return 0, including under bypass.
- Reads: rd1, rd2 and dbg_data are purely combinational from their address and the current state. There is no read latency.
- Bypass (BYPASS=1): rdN = wd when we=1, rst=0, wa=raN and wa!=0; otherwise rdN = reg[raN]. Both ports bypass independently; ra1=ra2=wa bypasses both.
- Bypass disabled (BYPASS=0): rdN = reg[raN] unconditionally. The old value is seen in the write cycle and the new value the next cycle.
- dbg_data: always the stored value, reg[dbg_addr], never bypassed.
- Counter: wr_count wraps modulo 2**CW, so 0xFFFF+1 gives 0x0000. No saturation and no overflow flag.
- Width rules: wd is stored unmodified, with no sign or zero extension inside the block. Addresses are used as-is; every value is in range by construction.
- X-handling: when we=0, the contents of wa and wd have no effect.

Test Plan:
- Reset: drive rst=1 for 2 cycles, then release. All 32 addresses read 0 on rd1, rd2 and dbg_data; wr_count=0; last_wa=0.
- Write/readback: write wa=5, wd=0xDEADBEEF; next cycle set ra1=5, ra2=5, dbg_addr=5. All three read 0xDEADBEEF; wr_count=1; last_wa=5.
- r0 protection: we=1, wa=0, wd=0x12345678. ra1=0 reads 0 in the same cycle and the next; wr_count and last_wa are unchanged.
- Bypass:
  - With BYPASS=1, reg[7]=0x11: write wa=7, wd=0x22 with ra1=7. rd1=0x22 in the write cycle, while dbg_addr=7 gives 0x11.
  - Repeat with BYPASS=0: rd1=0x11, then 0x22 on the next cycle.
- Reset collision: write wa=3, wd=0xAA with rst=1 on the same edge. Next cycle reg[3]=0 and wr_count=0; with rst=0, a rewrite of 0xAA then succeeds.
- Counter wrap: with CW=4, perform 17 writes to wa=1..17 (mod 32, skipping 0). wr_count reads 1 after the 17th write; last_wa=17.

Source files
------------

// File: rtl/regfile_wb.sv
// Write-back register file: 2**AW x DW registers, r0 hardwired to zero, two combinational
// read ports with optional write-to-read bypass, an unbypassed debug port and a commit counter.
module regfile_wb #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic [CW-1:0] wr_count,
    output logic [AW-1:0] last_wa
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0]   regs_reg [NREG];
    logic [NREG-1:0] wsel;
    logic            commit;
    logic [CW-1:0]   wr_count_reg;
    logic [AW-1:0]   last_wa_reg;

    // A write to address 0 is not a commit: it neither stores nor counts.
    assign commit = we && (wa != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_wsel
            assign wsel[gi] = commit && (wa == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
            wr_count_reg <= '0;
            last_wa_reg  <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wsel[i]) begin
                    regs_reg[i] <= wd;
                end
            end
            if (commit) begin
                wr_count_reg <= wr_count_reg + CW'(1);
                last_wa_reg  <= wa;
            end
        end
    end

    // Read ports: r0 forced to zero, then bypass of the in-flight write, else stored value.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [AW-1:0] ra_sel;
            logic [DW-1:0] rd_v;
            assign ra_sel = (gi == 0) ? ra1 : ra2;
            always_comb begin
                rd_v = regs_reg[ra_sel];
                if (ra_sel == '0) begin
                    rd_v = '0;
                end else if ((BYPASS != 0) && we && !rst && (wa == ra_sel)) begin
                    rd_v = wd;
                end
            end
        end
    endgenerate

    assign rd1      = g_rd[0].rd_v;
    assign rd2      = g_rd[1].rd_v;
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_reg[dbg_addr];
    assign wr_count = wr_count_reg;
    assign last_wa  = last_wa_reg;

endmodule

// File: tb/tb_regfile_wb.sv
// Randomized + directed bench for regfile_wb: one bypassing instance with a 4-bit counter,
// one non-bypassing instance with a 16-bit counter, both checked against an array model.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst, we;
    logic [4:0]  wa, ra1, ra2, dbg_addr;
    logic [31:0] wd;

    logic [31:0] b_rd1, b_rd2, b_dbg, n_rd1, n_rd2, n_dbg;
    logic [3:0]  b_cnt;
    logic [15:0] n_cnt;
    logic [4:0]  b_last, n_last;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [31:0] m_mem [32];
    int          m_count;
    logic [4:0]  m_last;

    always #5 clk = ~clk;

    regfile_wb #(.DW(32), .AW(5), .BYPASS(1), .CW(4)) u_dut_byp (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2),
        .dbg_addr(dbg_addr), .dbg_data(b_dbg),
        .wr_count(b_cnt), .last_wa(b_last)
    );

    regfile_wb #(.DW(32), .AW(5), .BYPASS(0), .CW(16)) u_dut_nobyp (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(n_rd1), .rd2(n_rd2),
        .dbg_addr(dbg_addr), .dbg_data(n_dbg),
        .wr_count(n_cnt), .last_wa(n_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] addr, input bit byp);
        if (addr == 5'd0) return 32'd0;
        if (byp && we && !rst && (wa == addr)) return wd;
        return m_mem[addr];
    endfunction

    // One clock cycle: drive inputs, check combinational outputs mid-cycle, advance model at the edge.
    task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] da,
                        input bit do_chk);
        rst = r; we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; dbg_addr = da;
        #2;
        $display("t=%0t rst=%0b we=%0b wa=%0d wd=%h ra1=%0d ra2=%0d dbg=%0d | byp rd1=%h rd2=%h cnt=%0d | nob rd1=%h cnt=%0d",
                 $time, r, w, a, d, r1, r2, da, b_rd1, b_rd2, b_cnt, n_rd1, n_cnt);
        if (do_chk) begin
            chk("byp_rd1",  b_rd1, exp_rd(r1, 1'b1));
            chk("byp_rd2",  b_rd2, exp_rd(r2, 1'b1));
            chk("byp_dbg",  b_dbg, exp_rd(da, 1'b0));
            chk("nob_rd1",  n_rd1, exp_rd(r1, 1'b0));
            chk("nob_rd2",  n_rd2, exp_rd(r2, 1'b0));
            chk("nob_dbg",  n_dbg, exp_rd(da, 1'b0));
            chk("byp_cnt",  {28'd0, b_cnt}, 32'(m_count % 16));
            chk("nob_cnt",  {16'd0, n_cnt}, 32'(m_count % 65536));
            chk("byp_last", {27'd0, b_last}, {27'd0, m_last});
            chk("nob_last", {27'd0, n_last}, {27'd0, m_last});
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
            m_count = 0;
            m_last  = 5'd0;
        end else if (w && a != 5'd0) begin
            m_mem[a] = d;
            m_count++;
            m_last = a;
        end
        #1;
    endtask

    initial begin
        logic [4:0]  ra, rb, wad;
        logic        rr, ww;
        for (int i = 0; i < 32; i++) m_mem[i] = 'x;
        m_count = 0;
        m_last  = 'x;

        // Reset for two cycles, then sweep all addresses
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 5'(i), 32'hFFFF_FFFF, 5'(i), 5'(31 - i), 5'(i), 1);
        end
        chk("rst_cnt", {28'd0, b_cnt}, 32'd0);

        // Write/readback
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1);
        step(0, 0, 0, 0, 5, 5, 5, 1);
        chk("wb_rd1", b_rd1, 32'hDEADBEEF);

        // r0 protection
        step(0, 1, 0, 32'h12345678, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 5, 0, 1);
        chk("r0_last", {27'd0, n_last}, 32'd5);

        // Bypass vs. no bypass on the same write
        step(0, 1, 7, 32'h11, 0, 0, 0, 1);
        step(0, 1, 7, 32'h22, 7, 7, 7, 1);
        step(0, 0, 0, 0, 7, 7, 7, 1);

        // Reset colliding with a write
        step(1, 1, 3, 32'hAA, 3, 3, 3, 1);
        step(0, 0, 0, 0, 3, 3, 3, 1);
        step(0, 1, 3, 32'hAA, 3, 0, 3, 1);
        step(0, 0, 0, 0, 3, 3, 3, 1);

        // Counter wrap on the 4-bit instance
        step(1, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 17; k++) begin
            step(0, 1, 5'(k), $urandom, 5'(k), 5'(k - 1), 5'(k), 1);
        end
        step(0, 0, 0, 0, 17, 1, 16, 1);
        chk("wrap_cnt", {28'd0, b_cnt}, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rr  = ($urandom_range(0, 39) == 0);
            ww  = $urandom_range(0, 3) != 0;
            wad = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            ra  = ($urandom_range(0, 2) == 0) ? wad : 5'($urandom_range(0, 31));
            rb  = ($urandom_range(0, 2) == 0) ? wad : 5'($urandom_range(0, 31));
            step(rr, ww, wad, $urandom, ra, rb, 5'($urandom_range(0, 31)), 1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
